bscan_spi_bridge: RTL and testbench

Parametrised JTAG-DR-to-SPI bridge, the successor to the single-flash boundary-scan loader. It hunts a magic-tagged header in the user-DR bit stream and drives one of `NUM_CS` SPI chip selects for a header-specified bit count. It captures MISO into an internal readback buffer and plays the buffer out on TDO during later scans. It sits between the device's BSCAN primitive, which supplies `DRCK` and the TAP strobes, and the board SPI pins.

---
 rtl/bscan_spi_pkg.sv | 9 +
 rtl/bscan_spi_rdbuf.sv | 18 +
 rtl/bscan_spi_bridge.sv | 73 +++++++
 tb/tb_bscan_spi_bridge.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bscan_spi_pkg.sv
// bscan_spi_pkg: shared constants, header sizing and FSM states for the JTAG-to-SPI bridge
package bscan_spi_pkg;
  localparam logic [31:0] MAGIC_DEF = 32'h59A659A6;
  localparam int CS_SEL_W = 8;
  function automatic int hdr_w(input int len_w);
    return 32 + CS_SEL_W + len_w;
  endfunction
  typedef enum logic [1:0] {HUNT, ARM, XFER, DONE} state_t;
endpackage

// File: rtl/bscan_spi_rdbuf.sv
// bscan_spi_rdbuf: 1-bit simple dual-port readback RAM with registered read
module bscan_spi_rdbuf #(
  parameter int DEPTH = 16384,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [AW-1:0] wa,
  input logic wd,
  input logic re,
  input logic [AW-1:0] ra,
  output logic rd
);
  logic mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk) rd <= rst ? 1'b0 : re ? mem[ra] : rd;
endmodule

// File: rtl/bscan_spi_bridge.sv
// bscan_spi_bridge: user-DR header hunter driving SPI chip selects with MISO capture and TDO readback
module bscan_spi_bridge
  import bscan_spi_pkg::*;
#(
  parameter int NUM_CS = 1,
  parameter int LEN_W = 16,
  parameter int DEPTH = 16384,
  parameter logic [31:0] MAGIC = MAGIC_DEF
) (
  input logic DRCK,
  input logic rst,
  input logic sel,
  input logic shift,
  input logic capture,
  input logic update,
  input logic tdi,
  output logic tdo,
  output logic spi_mosi,
  output logic [NUM_CS-1:0] spi_cs_n,
  input logic spi_miso,
  output logic ovf,
  output logic busy
);
  localparam int HW = hdr_w(LEN_W);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [HW-1:0] hdr_sr;
  logic [LEN_W-1:0] hdr_len, cnt;
  logic [CS_SEL_W-1:0] hdr_cs, cs_idx;
  logic [AW:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic fresh, abort, hit, run, fin, cs_ok, wr_en;
  assign abort = rst | capture | update | ~sel;
  assign spi_mosi = tdi;
  assign hdr_len = hdr_sr[LEN_W-1:0];
  assign hdr_cs = hdr_sr[LEN_W +: CS_SEL_W];
  assign busy = state == ARM || state == XFER;
  assign hit = !abort && fresh && state == HUNT && hdr_sr[HW-1 -: 32] == MAGIC && hdr_len != '0;
  assign run = !abort && busy;
  assign fin = run && cnt == LEN_W'(1);
  assign cs_ok = int'(cs_idx) < NUM_CS;
  assign wr_en = run && cs_ok && !wr_ptr[AW];
  always_comb state_n = abort ? HUNT : hit ? ARM : fin ? DONE : state == ARM ? XFER : state;
  always_ff @(posedge DRCK) begin
    state <= state_n;
    fresh <= shift & ~rst;
    if (rst) hdr_sr <= '0;
    else if (shift) hdr_sr <= {hdr_sr[HW-2:0], tdi};
    rd_ptr <= abort ? '0 : shift ? rd_ptr + AW'(1) : rd_ptr;
    spi_cs_n <= (abort || fin) ? '1 : hit ? ~(NUM_CS'(1) << hdr_cs) : spi_cs_n;
    if (rst) begin
      cnt <= '0;
      cs_idx <= '0;
    end else if (hit) begin
      cnt <= hdr_len;
      cs_idx <= hdr_cs;
    end else if (run) cnt <= cnt - LEN_W'(1);
    if (rst || hit) wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
    if (rst || hit) ovf <= 1'b0;
    else if (run && cs_ok && wr_ptr[AW]) ovf <= 1'b1;
  end
  bscan_spi_rdbuf #(.DEPTH(DEPTH)) u_buf (
    .clk(DRCK),
    .rst(rst),
    .we(wr_en),
    .wa(wr_ptr[AW-1:0]),
    .wd(spi_miso),
    .re(shift),
    .ra(rd_ptr),
    .rd(tdo)
  );
endmodule

// File: tb/tb_bscan_spi_bridge.sv
// tb_bscan_spi_bridge: directed/random header transfers checked against a transfer-level model
module tb_bscan_spi_bridge;
  import bscan_spi_pkg::*;
  localparam int NCS = 4;
  localparam int LW = 16;
  localparam int DP = 16;
  localparam logic [31:0] MG = 32'h59A659A6;
  logic DRCK = 1'b0;
  logic rst, sel, shift, capture, update, tdi, spi_miso;
  logic tdo, spi_mosi, ovf, busy;
  logic [NCS-1:0] spi_cs_n;
  int total = 0;
  int bad = 0;
  logic [NCS-1:0] cs_q[$];
  logic busy_q[$];
  logic ovf_q[$];
  bit mb[DP];
  bit known[DP];
  int m_wr = 0;
  bit m_ovf = 1'b0;
  bscan_spi_bridge #(.NUM_CS(NCS), .LEN_W(LW), .DEPTH(DP), .MAGIC(MG)) dut (
    .DRCK(DRCK),
    .rst(rst),
    .sel(sel),
    .shift(shift),
    .capture(capture),
    .update(update),
    .tdi(tdi),
    .tdo(tdo),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso),
    .ovf(ovf),
    .busy(busy)
  );
  always #5 DRCK = ~DRCK;
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic t, input logic m);
    tdi = t;
    spi_miso = m;
    #1;
    chk("mosi", spi_mosi, t);
    @(posedge DRCK);
    #1;
    cs_q.push_back(spi_cs_n);
    busy_q.push_back(busy);
    ovf_q.push_back(ovf);
  endtask
  task automatic run(input logic [31:0] mg, input int cs, input int len, input int ab,
                     input logic [15:0] pat, input bit fixed);
    logic [55:0] h;
    bit resp[$];
    int k, hi, nx, nw, cnt_l;
    bit valid, in_r, act, e_ovf;
    logic [NCS-1:0] e_cs;
    h = {mg, 8'(cs), 16'(len)};
    valid = mg == MG && len > 0;
    in_r = cs < NCS;
    hi = !valid ? 0 : (ab < 0 || ab > len) ? len : ab;
    nx = !valid ? 0 : (ab < 0 || ab - 1 > len) ? len : (ab > 0 ? ab - 1 : 0);
    nw = in_r ? (nx < DP ? nx : DP) : 0;
    for (int n = 0; n < len; n++) resp.push_back(fixed ? pat[15 - n] : 1'($urandom));
    cs_q.delete();
    busy_q.delete();
    ovf_q.delete();
    for (int i = 55; i >= 0; i--) step(h[i], 1'b0);
    k = cs_q.size() - 1;
    for (int j = 0; j <= len; j++) begin
      sel = j != ab;
      step(j < len ? 1'($urandom) : 1'b0, j > 0 ? resp[j - 1] : 1'b0);
    end
    sel = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    shift = 1'b0;
    update = 1'b1;
    step(1'b0, 1'b0);
    update = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < cs_q.size(); i++) begin
      act = valid && i >= k + 1 && i <= k + hi;
      e_cs = (act && in_r) ? ~(NCS'(1) << cs) : '1;
      e_ovf = (!valid || i <= k) ? m_ovf : (in_r && nx > DP && i >= k + 2 + DP);
      chk($sformatf("cs_n@%0d", i - k), cs_q[i], e_cs);
      chk($sformatf("busy@%0d", i - k), busy_q[i], act);
      chk($sformatf("ovf@%0d", i - k), ovf_q[i], e_ovf);
    end
    for (int c = 0; c < NCS; c++) begin
      cnt_l = 0;
      for (int i = 1; i < cs_q.size(); i++) if (!cs_q[i][c] || !cs_q[i - 1][c]) cnt_l++;
      chk($sformatf("cs_edges[%0d]", c), cnt_l, (valid && in_r && c == cs && hi > 0) ? hi + 1 : 0);
    end
    cnt_l = 0;
    for (int i = 1; i < busy_q.size(); i++) if (busy_q[i] || busy_q[i - 1]) cnt_l++;
    chk("busy_edges", cnt_l, hi > 0 ? hi + 1 : 0);
    if (valid) begin
      m_wr = nw;
      m_ovf = in_r && nx > DP;
      for (int n = 0; n < nw; n++) begin
        mb[n] = resp[n];
        known[n] = 1'b1;
      end
    end
    chk("wr_ptr", dut.wr_ptr, m_wr);
    chk("state", dut.state, HUNT);
  endtask
  task automatic readback();
    shift = 1'b0;
    capture = 1'b1;
    step(1'b0, 1'b0);
    capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b0);
      if (known[i]) chk($sformatf("tdo[%0d]", i), tdo, mb[i]);
    end
    shift = 1'b0;
    update = 1'b1;
    step(1'b0, 1'b0);
    update = 1'b0;
    shift = 1'b1;
  endtask
  initial begin
    rst = 1'b1;
    sel = 1'b0;
    shift = 1'b0;
    capture = 1'b0;
    update = 1'b0;
    tdi = 1'b0;
    spi_miso = 1'b0;
    repeat (3) @(posedge DRCK);
    #1;
    chk("rst_cs_n", spi_cs_n, {NCS{1'b1}});
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    sel = 1'b1;
    shift = 1'b1;
    run(MG, 0, 16, -1, 16'hA5C3, 1'b1);
    readback();
    run(MG, 2, 8, -1, 16'h0, 1'b0);
    run(MG, 5, 8, -1, 16'h0, 1'b0);
    run(MG, 1, 20, -1, 16'h0, 1'b0);
    readback();
    run(MG, 3, 32, 5, 16'h0, 1'b0);
    run(MG, 0, 12, -1, 16'h0, 1'b0);
    readback();
    run(MG, 1, 0, -1, 16'h0, 1'b0);
    run(MG ^ 32'h0000_1000, 2, 10, -1, 16'h0, 1'b0);
    run(MG, 3, $urandom_range(25, 1), -1, 16'h0, 1'b0);
    readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
